// File: rtl/sint_minmax_pkg.sv
// Shared types and constants for the signed min/max stream tracker.
package sint_minmax_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  // All-ones value of a w-bit counter, i.e. 2^w - 1.
  function automatic logic [31:0] cnt_max(input int unsigned w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/sint_sle_cmp.sv
// Combinational full-width signed less-or-equal compare: le = (a <= b).
module sint_sle_cmp #(
  parameter int WIDTH = 3
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic                    le
);

  assign le = (a <= b);

endmodule

// File: rtl/sint_minmax_tracker.sv
// Framed signed min/max/count reducer with valid/ready in and summary out.
// Optional argmin/argmax outputs are enabled by defining SINT_MINMAX_ARGIDX_EN.
module sint_minmax_tracker
  import sint_minmax_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int CNT_W = 4
) (
  input  logic                    CLK,
  input  logic                    ASYNCRESETN,
  input  logic                    I_valid,
  output logic                    I_ready,
  input  logic signed [WIDTH-1:0] I_data,
  input  logic                    I_last,
  output logic                    O_valid,
  input  logic                    O_ready,
  output logic signed [WIDTH-1:0] O_min,
  output logic signed [WIDTH-1:0] O_max,
  output logic [CNT_W-1:0]        O_count
`ifdef SINT_MINMAX_ARGIDX_EN
  ,
  output logic [CNT_W-1:0]        O_min_idx,
  output logic [CNT_W-1:0]        O_max_idx
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_W'(1);
  endfunction

  state_t state;
  logic   accept;
  logic   min_le;
  logic   max_le;

  assign accept = I_valid && I_ready;

  // min_le low means the sample is strictly below the running minimum.
  sint_sle_cmp #(.WIDTH(WIDTH)) u_min_cmp (
    .a  (O_min),
    .b  (I_data),
    .le (min_le)
  );

  sint_sle_cmp #(.WIDTH(WIDTH)) u_max_cmp (
    .a  (I_data),
    .b  (O_max),
    .le (max_le)
  );

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state     <= ST_IDLE;
      I_ready   <= 1'b1;
      O_valid   <= 1'b0;
      O_min     <= '0;
      O_max     <= '0;
      O_count   <= '0;
`ifdef SINT_MINMAX_ARGIDX_EN
      O_min_idx <= '0;
      O_max_idx <= '0;
`endif
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            O_min     <= I_data;
            O_max     <= I_data;
            O_count   <= CNT_W'(1);
`ifdef SINT_MINMAX_ARGIDX_EN
            O_min_idx <= '0;
            O_max_idx <= '0;
`endif
            if (I_last) begin
              state   <= ST_HOLD;
              I_ready <= 1'b0;
              O_valid <= 1'b1;
            end else begin
              state   <= ST_ACCUM;
            end
          end
        end
        ST_ACCUM: begin
          if (accept) begin
            // Pre-increment count is the sample's position; it pins at CNT_MAX.
            if (!min_le) begin
              O_min     <= I_data;
`ifdef SINT_MINMAX_ARGIDX_EN
              O_min_idx <= O_count;
`endif
            end
            if (!max_le) begin
              O_max     <= I_data;
`ifdef SINT_MINMAX_ARGIDX_EN
              O_max_idx <= O_count;
`endif
            end
            O_count <= sat_inc(O_count);
            if (I_last) begin
              state   <= ST_HOLD;
              I_ready <= 1'b0;
              O_valid <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (O_ready) begin
            state   <= ST_IDLE;
            I_ready <= 1'b1;
            O_valid <= 1'b0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          I_ready <= 1'b1;
          O_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
